// File: rtl/rvc_pkg.sv
// Shared constants for the RVC fetch aligner: RV32I opcodes, NOP and
// compressed quadrant / funct3 encodings.
package rvc_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        Q0 = 2'b00,
        Q1 = 2'b01,
        Q2 = 2'b10,
        Q3 = 2'b11
    } quad_e;

    typedef enum logic [2:0] {
        F3_ADDI4SPN_ADDI_SLLI = 3'b000,
        F3_JAL                = 3'b001,
        F3_LW_LI_LWSP         = 3'b010,
        F3_LUI                = 3'b011,
        F3_ALU_MISC           = 3'b100,
        F3_J                  = 3'b101,
        F3_SW_BEQZ_SWSP       = 3'b110,
        F3_BNEZ               = 3'b111
    } cf3_e;

endpackage

// File: rtl/rvc_expand.sv
// Combinational RVC -> RV32I expander.
// Define RVC_FULL_EN to add C.LI/LUI/ADDI16SP/ADDI4SPN/LWSP/SWSP/SUB/XOR/OR/AND/EBREAK.
module rvc_expand
    import rvc_pkg::*;
(
    input  logic [15:0] half,
    output logic [31:0] inst,
    output logic        jal,
    output logic        jalr,
    output logic        illegal
);

    quad_e       q;
    cf3_e        f3;
    logic [4:0]  rd;
    logic [4:0]  rs2;
    logic [4:0]  rs1p;
    logic [4:0]  rs2p;
    logic [11:0] imm6;
    logic [11:0] mem_w;
    logic [20:0] jimm;
    logic [12:0] bimm;

    assign q     = quad_e'(half[1:0]);
    assign f3    = cf3_e'(half[15:13]);
    assign rd    = half[11:7];
    assign rs2   = half[6:2];
    assign rs1p  = {2'b01, half[9:7]};
    assign rs2p  = {2'b01, half[4:2]};
    assign imm6  = {{7{half[12]}}, half[6:2]};
    assign mem_w = {5'b0, half[5], half[12:10], half[6], 2'b00};
    assign jimm  = {{9{half[12]}}, half[12], half[8], half[10:9], half[6],
                    half[7], half[2], half[11], half[5:3], 1'b0};
    assign bimm  = {{4{half[12]}}, half[12], half[6:5], half[2],
                    half[11:10], half[4:3], 1'b0};

`ifdef RVC_FULL_EN
    logic [11:0] a4_imm;
    logic [11:0] a16_imm;
    logic [11:0] lwsp_imm;
    logic [11:0] swsp_imm;
    logic [19:0] lui_imm;
    logic [2:0]  alu_f3;

    assign a4_imm   = {2'b0, half[10:7], half[12:11], half[5], half[6], 2'b00};
    assign a16_imm  = {{2{half[12]}}, half[12], half[4:3], half[5], half[2],
                       half[6], 4'b0};
    assign lwsp_imm = {4'b0, half[3:2], half[12], half[6:4], 2'b00};
    assign swsp_imm = {4'b0, half[8:7], half[12:9], 2'b00};
    assign lui_imm  = {{14{half[12]}}, half[12], half[6:2]};
    assign alu_f3   = (half[6:5] == 2'b00) ? 3'b000 :
                      (half[6:5] == 2'b01) ? 3'b100 :
                      (half[6:5] == 2'b10) ? 3'b110 : 3'b111;
`endif

    always_comb begin
        inst    = NOP;
        jal     = 1'b0;
        jalr    = 1'b0;
        illegal = 1'b0;
        case (q)
            Q0: case (f3)
`ifdef RVC_FULL_EN
                F3_ADDI4SPN_ADDI_SLLI: begin
                    illegal = (half[12:5] == 8'd0);
                    inst = {a4_imm, 5'd2, 3'b000, rs2p, OP_IMM};
                end
`endif
                F3_LW_LI_LWSP:
                    inst = {mem_w, rs1p, 3'b010, rs2p, LOAD};
                F3_SW_BEQZ_SWSP:
                    inst = {mem_w[11:5], rs2p, rs1p, 3'b010, mem_w[4:0], STORE};
                default: illegal = 1'b1;
            endcase
            Q1: case (f3)
                F3_ADDI4SPN_ADDI_SLLI:
                    inst = {imm6, rd, 3'b000, rd, OP_IMM};
                F3_JAL: begin
                    jal  = 1'b1;
                    inst = {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd1, JAL};
                end
                F3_J:
                    inst = {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd0, JAL};
                F3_SW_BEQZ_SWSP:
                    inst = {bimm[12], bimm[10:5], 5'd0, rs1p, 3'b000,
                            bimm[4:1], bimm[11], BRANCH};
                F3_BNEZ:
                    inst = {bimm[12], bimm[10:5], 5'd0, rs1p, 3'b001,
                            bimm[4:1], bimm[11], BRANCH};
`ifdef RVC_FULL_EN
                F3_LW_LI_LWSP:
                    inst = {imm6, 5'd0, 3'b000, rd, OP_IMM};
                F3_LUI: begin
                    // rd=x2 selects C.ADDI16SP; a zero immediate is reserved for both
                    illegal = ({half[12], half[6:2]} == 6'd0);
                    if (rd == 5'd2)
                        inst = {a16_imm, 5'd2, 3'b000, 5'd2, OP_IMM};
                    else
                        inst = {lui_imm, rd, LUI};
                end
`endif
                F3_ALU_MISC: case (half[11:10])
                    2'b00: begin
                        illegal = half[12];
                        inst = {7'b0000000, rs2, rs1p, 3'b101, rs1p, OP_IMM};
                    end
                    2'b01: begin
                        illegal = half[12];
                        inst = {7'b0100000, rs2, rs1p, 3'b101, rs1p, OP_IMM};
                    end
                    2'b10:
                        inst = {imm6, rs1p, 3'b111, rs1p, OP_IMM};
                    default: begin
`ifdef RVC_FULL_EN
                        illegal = half[12];
                        inst = {1'b0, half[6:5] == 2'b00, 5'b0, rs2p, rs1p,
                                alu_f3, rs1p, OP};
`else
                        illegal = 1'b1;
`endif
                    end
                endcase
                default: illegal = 1'b1;
            endcase
            Q2: case (f3)
                F3_ADDI4SPN_ADDI_SLLI: begin
                    illegal = half[12];
                    inst = {7'b0000000, rs2, rd, 3'b001, rd, OP_IMM};
                end
`ifdef RVC_FULL_EN
                F3_LW_LI_LWSP: begin
                    illegal = (rd == 5'd0);
                    inst = {lwsp_imm, 5'd2, 3'b010, rd, LOAD};
                end
                F3_SW_BEQZ_SWSP:
                    inst = {swsp_imm[11:5], rs2, 5'd2, 3'b010, swsp_imm[4:0], STORE};
`endif
                F3_ALU_MISC: begin
                    if (!half[12]) begin
                        if (rs2 != 5'd0)
                            inst = {7'b0, rs2, 5'd0, 3'b000, rd, OP};
                        else begin
                            illegal = (rd == 5'd0);
                            inst = {12'b0, rd, 3'b000, 5'd0, JALR};
                        end
                    end else if (rs2 != 5'd0) begin
                        inst = {7'b0, rs2, rd, 3'b000, rd, OP};
                    end else if (rd != 5'd0) begin
                        jalr = 1'b1;
                        inst = {12'b0, rd, 3'b000, 5'd1, JALR};
                    end else begin
`ifdef RVC_FULL_EN
                        inst = 32'h0010_0073;
`else
                        illegal = 1'b1;
`endif
                    end
                end
                default: illegal = 1'b1;
            endcase
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            inst = NOP;
            jal  = 1'b0;
            jalr = 1'b0;
        end
    end

endmodule

// File: rtl/rvc_fetch_aligner.sv
// Halfword FIFO that aligns 32-bit fetch words into whole RV32IC instructions.
// Compressed expansion set is widened by defining RVC_FULL_EN.
module rvc_fetch_aligner
    import rvc_pkg::*;
#(
    parameter int BUF_HW = 4,
    parameter int PC_W   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_valid,
    output logic            fetch_ready,
    input  logic [31:0]     fetch_data,
    input  logic            flush,
    input  logic [PC_W-1:0] flush_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [PC_W-1:0] out_pc,
    output logic            out_is_comp,
    output logic            out_jal,
    output logic            out_jalr,
    output logic            out_illegal
);

    localparam int AW = $clog2(BUF_HW);
    localparam int CW = AW + 1;

    logic [15:0]     mem [BUF_HW];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [PC_W-1:0] head_pc;
    logic            drop;

    logic [15:0]     head;
    logic [15:0]     second;
    logic            is32;
    logic            avail;
    logic            pop;
    logic            push;
    logic [CW-1:0]   need;
    logic [CW-1:0]   pop_n;
    logic [CW-1:0]   push_n;
    logic [CW-1:0]   free_after;
    logic [31:0]     x_inst;
    logic            x_jal;
    logic            x_jalr;
    logic            x_ill;

    assign head       = mem[rd_ptr];
    assign second     = mem[rd_ptr + AW'(1)];
    assign is32       = (head[1:0] == 2'b11);
    assign need       = is32 ? CW'(2) : CW'(1);
    assign avail      = !rst && (count >= need);
    assign pop        = avail && out_ready;
    assign pop_n      = pop ? need : '0;
    assign free_after = CW'(BUF_HW) - count + pop_n;
    assign fetch_ready = !rst && !flush && (free_after >= CW'(2));
    assign push       = fetch_valid && fetch_ready;
    assign push_n     = push ? (drop ? CW'(1) : CW'(2)) : '0;

    rvc_expand u_expand (
        .half    (head),
        .inst    (x_inst),
        .jal     (x_jal),
        .jalr    (x_jalr),
        .illegal (x_ill)
    );

    assign out_valid   = avail;
    assign out_inst    = !avail ? '0 : (is32 ? {second, head} : x_inst);
    assign out_pc      = avail ? head_pc : '0;
    assign out_is_comp = avail && !is32;
    assign out_jal     = avail && !is32 && x_jal;
    assign out_jalr    = avail && !is32 && x_jalr;
    assign out_illegal = avail && !is32 && x_ill;

    // Storage carries no reset; validity is tracked purely by count
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            if (drop) begin
                mem[wr_ptr] <= fetch_data[31:16];
            end else begin
                mem[wr_ptr]          <= fetch_data[15:0];
                mem[wr_ptr + AW'(1)] <= fetch_data[31:16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            head_pc <= '0;
            drop    <= 1'b0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            head_pc <= flush_pc & ~PC_W'(1);
            drop    <= flush_pc[1];
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + push_n[AW-1:0];
                drop   <= 1'b0;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + pop_n[AW-1:0];
                head_pc <= head_pc + (is32 ? PC_W'(4) : PC_W'(2));
            end
            count <= count + push_n - pop_n;
        end
    end

endmodule
